// File: rtl/lcd_hd44780_pkg.sv
// ============================================================================
// Module      : lcd_hd44780_pkg
// Description : Shared opcode classes, DDRAM address constants and AC helpers
//               for the HD44780 4-bit bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_hd44780_pkg;

  typedef enum logic [3:0] {
    OPC_NOP,
    OPC_CLR,
    OPC_HOME,
    OPC_ENTRY,
    OPC_DISP,
    OPC_SHIFT,
    OPC_FUNC,
    OPC_CGRAM,
    OPC_DDRAM
  } op_class_t;

  localparam logic [6:0] c_line1_base = 7'h00;
  localparam logic [6:0] c_line2_base = 7'h40;
  localparam logic [6:0] c_line1_end  = 7'h27;
  localparam logic [6:0] c_line2_end  = 7'h67;
  localparam logic [7:0] c_blank      = 8'h20;

  // Instruction class is selected by the highest set bit of the byte.
  function automatic op_class_t op_class(input logic [7:0] b);
    if (b[7])      return OPC_DDRAM;
    else if (b[6]) return OPC_CGRAM;
    else if (b[5]) return OPC_FUNC;
    else if (b[4]) return OPC_SHIFT;
    else if (b[3]) return OPC_DISP;
    else if (b[2]) return OPC_ENTRY;
    else if (b[1]) return OPC_HOME;
    else if (b[0]) return OPC_CLR;
    else           return OPC_NOP;
  endfunction

  function automatic logic [4:0] ac_to_idx(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == c_line1_end)      return c_line2_base;
      else if (ac == c_line2_end) return c_line1_base;
      else                        return ac + 7'd1;
    end else begin
      if (ac == c_line1_base)      return c_line2_end;
      else if (ac == c_line2_base) return c_line1_end;
      else                         return ac - 7'd1;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_bus_capture.sv
// ============================================================================
// Module      : lcd_bus_capture
// Description : Bus synchronizer, E falling-edge detect and nibble assembler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic [3:0] lcd_db,
  input  logic       mode_4bit,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs
);

  logic [SYNC_STAGES-1:0]      r_e_sync;
  logic [SYNC_STAGES-1:0]      r_rs_sync;
  logic [SYNC_STAGES-1:0][3:0] r_db_sync;
  logic                        r_e_last;
  logic                        r_mode_last;
  logic                        r_phase;
  logic [3:0]                  r_hi_nib;
  logic                        w_e_s;
  logic                        w_rs_s;
  logic [3:0]                  w_db_s;
  logic                        w_fall;

  assign w_e_s  = r_e_sync[SYNC_STAGES-1];
  assign w_rs_s = r_rs_sync[SYNC_STAGES-1];
  assign w_db_s = r_db_sync[SYNC_STAGES-1];
  assign w_fall = r_e_last & ~w_e_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_sync    <= '0;
      r_rs_sync   <= '0;
      r_db_sync   <= '0;
      r_e_last    <= 1'b0;
      r_mode_last <= 1'b0;
      r_phase     <= 1'b0;
      r_hi_nib    <= 4'h0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'h00;
      byte_rs     <= 1'b0;
    end else begin
      r_e_sync    <= {r_e_sync[SYNC_STAGES-2:0], lcd_e};
      r_rs_sync   <= {r_rs_sync[SYNC_STAGES-2:0], lcd_rs};
      r_db_sync   <= {r_db_sync[SYNC_STAGES-2:0], lcd_db};
      r_e_last    <= w_e_s;
      r_mode_last <= mode_4bit;
      byte_valid  <= 1'b0;
      // Switching into 4-bit mode always restarts on a high nibble.
      if (mode_4bit && !r_mode_last) r_phase <= 1'b0;
      if (w_fall) begin
        if (!mode_4bit) begin
          byte_valid <= 1'b1;
          byte_data  <= {w_db_s, 4'h0};
          byte_rs    <= w_rs_s;
        end else if (!r_phase) begin
          r_hi_nib <= w_db_s;
          r_phase  <= 1'b1;
        end else begin
          byte_valid <= 1'b1;
          byte_data  <= {r_hi_nib, w_db_s};
          byte_rs    <= w_rs_s;
          r_phase    <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_hd44780_rx.sv
// ============================================================================
// Module      : lcd_hd44780_rx
// Description : HD44780 4-bit bus responder with DDRAM shadow and busy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_hd44780_rx
  import lcd_hd44780_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_e,
  input  logic [3:0] lcd_db,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [4:0] cursor_idx,
  output logic       cursor_vis,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       two_line,
  output logic       mode_4bit,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       cmd_rs,
  output logic       err_busy
);

  localparam int c_cnt_max = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [1:0] c_st_fill_por = 2'd0;
  localparam logic [1:0] c_st_fill_clr = 2'd1;
  localparam logic [1:0] c_st_run      = 2'd2;

  if (SYNC_STAGES < 2 || CLK_FREQ <= 0) begin : g_param_check
    $error("lcd_hd44780_rx: SYNC_STAGES must be >= 2 and CLK_FREQ positive");
  end

  logic               w_cap_valid;
  logic [7:0]         w_cap_byte;
  logic               w_cap_rs;
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               w_filling;
  logic [4:0]         r_fill_idx;
  logic [c_cnt_w-1:0] r_busy_cnt;
  logic               r_pend_valid;
  logic [7:0]         r_pend_byte;
  logic               r_pend_rs;
  logic [6:0]         r_ac;
  logic               r_cgram;
  logic [7:0]         r_ddram [32];
  logic               w_in_run;
  logic               w_exec;
  logic [7:0]         w_exec_byte;
  logic               w_exec_rs;
  op_class_t          w_cls;
  logic               w_clear;
  logic               w_data_we;

  lcd_bus_capture #(.SYNC_STAGES(SYNC_STAGES)) u_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_db     (lcd_db),
    .mode_4bit  (mode_4bit),
    .byte_valid (w_cap_valid),
    .byte_data  (w_cap_byte),
    .byte_rs    (w_cap_rs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_fill_por;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_fill_por, c_st_fill_clr: if (r_fill_idx == 5'd31) w_state_nxt = c_st_run;
      c_st_run:                     if (w_clear) w_state_nxt = c_st_fill_clr;
      default:                      w_state_nxt = c_st_fill_por;
    endcase
  end

  always_comb begin
    w_filling = (r_state != c_st_run);
    w_in_run  = (r_state == c_st_run);
  end

  // A held byte always goes first once the fill is done.
  assign w_exec      = w_in_run && (r_pend_valid || w_cap_valid);
  assign w_exec_byte = r_pend_valid ? r_pend_byte : w_cap_byte;
  assign w_exec_rs   = r_pend_valid ? r_pend_rs : w_cap_rs;
  assign w_cls       = op_class(w_exec_byte);
  assign w_clear     = w_exec && !w_exec_rs && (w_cls == OPC_CLR);
  assign w_data_we   = w_exec && w_exec_rs && !r_cgram && (r_ac[5:4] == 2'b00);

  assign busy       = w_filling || (r_busy_cnt != '0);
  assign cursor_vis = !r_cgram && (r_ac[5:4] == 2'b00);
  assign cursor_idx = ac_to_idx(r_ac);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_idx   <= 5'd0;
      r_pend_valid <= 1'b0;
      r_pend_byte  <= 8'h00;
      r_pend_rs    <= 1'b0;
      err_busy     <= 1'b0;
    end else begin
      if (w_filling) r_fill_idx <= r_fill_idx + 5'd1;
      if (w_cap_valid && busy) err_busy <= 1'b1;
      // Bytes during the power-on fill are dropped; during a clear fill they wait.
      if (w_cap_valid && (r_state != c_st_fill_por) && (!w_in_run || r_pend_valid)) begin
        r_pend_valid <= 1'b1;
        r_pend_byte  <= w_cap_byte;
        r_pend_rs    <= w_cap_rs;
      end else if (w_exec && r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cnt  <= '0;
      r_ac        <= c_line1_base;
      r_cgram     <= 1'b0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      entry_inc   <= 1'b1;
      entry_shift <= 1'b0;
      two_line    <= 1'b0;
      mode_4bit   <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'h00;
      cmd_rs      <= 1'b0;
    end else begin
      cmd_valid <= w_exec;
      if (w_exec) begin
        cmd_byte   <= w_exec_byte;
        cmd_rs     <= w_exec_rs;
        r_busy_cnt <= (!w_exec_rs && (w_cls == OPC_CLR || w_cls == OPC_HOME))
                      ? c_cnt_w'(CLEAR_CYCLES) : c_cnt_w'(BUSY_CYCLES);
        if (w_exec_rs) begin
          if (!r_cgram) r_ac <= ac_step(r_ac, entry_inc);
        end else begin
          case (w_cls)
            OPC_CLR: begin
              r_ac      <= c_line1_base;
              entry_inc <= 1'b1;
            end
            OPC_HOME:  r_ac <= c_line1_base;
            OPC_ENTRY: begin
              entry_inc   <= w_exec_byte[1];
              entry_shift <= w_exec_byte[0];
            end
            OPC_DISP: begin
              disp_on   <= w_exec_byte[2];
              cursor_on <= w_exec_byte[1];
              blink_on  <= w_exec_byte[0];
            end
            OPC_SHIFT: if (!w_exec_byte[3]) r_ac <= ac_step(r_ac, w_exec_byte[2]);
            OPC_FUNC: begin
              mode_4bit <= ~w_exec_byte[4];
              two_line  <= w_exec_byte[3];
            end
            OPC_CGRAM: r_cgram <= 1'b1;
            OPC_DDRAM: begin
              r_ac    <= w_exec_byte[6:0];
              r_cgram <= 1'b0;
            end
            default: ;
          endcase
        end
      end else if (r_busy_cnt != '0) begin
        r_busy_cnt <= r_busy_cnt - c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_filling)      r_ddram[r_fill_idx] <= c_blank;
    else if (w_data_we) r_ddram[ac_to_idx(r_ac)] <= w_exec_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= r_ddram[rd_addr];
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_hd44780_rx.sv
// ============================================================================
// Module      : tb_lcd_hd44780_rx
// Description : Randomized self-checking bench against a byte-level LCD model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_hd44780_rx;

  localparam int BUSY_CYC  = 40;
  localparam int CLEAR_CYC = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_e = 1'b0;
  logic [3:0] lcd_db = 4'h0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       busy, cursor_vis, disp_on, cursor_on, blink_on;
  logic       entry_inc, entry_shift, two_line, mode_4bit;
  logic       cmd_valid, cmd_rs, err_busy;
  logic [4:0] cursor_idx;
  logic [7:0] cmd_byte;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_dd [32];
  int         m_ac;
  bit         m_cgram, m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_m4, m_err;

  lcd_hd44780_rx #(
    .CLK_FREQ(50000000), .BUSY_CYCLES(BUSY_CYC), .CLEAR_CYCLES(CLEAR_CYC), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_db(lcd_db),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .cursor_idx(cursor_idx),
    .cursor_vis(cursor_vis), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .entry_shift(entry_shift), .two_line(two_line),
    .mode_4bit(mode_4bit), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_rs(cmd_rs),
    .err_busy(err_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ac_next(input int ac, input bit inc);
    if (inc) return (ac == 'h27) ? 'h40 : (ac == 'h67) ? 'h00 : (ac + 1) % 128;
    else     return (ac == 'h00) ? 'h67 : (ac == 'h40) ? 'h27 : ac - 1;
  endfunction

  function automatic bit m_vis();
    return !m_cgram && ((m_ac < 'h10) || (m_ac >= 'h40 && m_ac < 'h50));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_dd[i] = 8'h20;
    m_ac = 0; m_cgram = 0; m_disp = 0; m_cur = 0; m_blink = 0;
    m_inc = 1; m_shift = 0; m_two = 0; m_m4 = 0; m_err = 0;
  endtask

  task automatic model_exec(input bit rs, input logic [7:0] b);
    int v;
    v = int'(b);
    if (rs) begin
      if (!m_cgram) begin
        if (m_vis()) m_dd[(m_ac >= 'h40 ? 16 : 0) + m_ac % 16] = b;
        m_ac = ac_next(m_ac, m_inc);
      end
    end else if (v >= 'h80) begin m_ac = v - 'h80; m_cgram = 0; end
    else if (v >= 'h40) m_cgram = 1;
    else if (v >= 'h20) begin m_m4 = (v & 16) == 0; m_two = (v & 8) != 0; end
    else if (v >= 'h10) begin if ((v & 8) == 0) m_ac = ac_next(m_ac, (v & 4) != 0); end
    else if (v >= 'h08) begin m_disp = (v & 4) != 0; m_cur = (v & 2) != 0; m_blink = (v & 1) != 0; end
    else if (v >= 'h04) begin m_inc = (v & 2) != 0; m_shift = (v & 1) != 0; end
    else if (v >= 'h02) m_ac = 0;
    else if (v == 'h01) begin
      for (int i = 0; i < 32; i++) m_dd[i] = 8'h20;
      m_ac = 0; m_inc = 1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic strobe(input logic rs, input logic [3:0] nib, input bit completes,
                        input logic [7:0] exp_byte);
    int n = 0;
    @(negedge clk);
    lcd_rs = rs; lcd_db = nib; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    if (!completes) begin
      repeat (4) @(negedge clk);
    end else begin
      while (!cmd_valid && n < 100) begin @(negedge clk); n++; end
      if (!cmd_valid) check("cmd_valid_timeout", 32'd0, 32'd1);
      else begin
        check("cmd_byte", 32'(cmd_byte), 32'(exp_byte));
        check("cmd_rs", 32'(cmd_rs), 32'(rs));
      end
    end
  endtask

  task automatic check_state();
    check("flags", 32'({disp_on, cursor_on, blink_on, entry_inc, entry_shift, two_line, mode_4bit}),
          32'({m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_m4}));
    check("cursor_vis", 32'(cursor_vis), 32'(m_vis()));
    if (m_vis())
      check("cursor_idx", 32'(cursor_idx), 32'((m_ac >= 'h40 ? 16 : 0) + m_ac % 16));
    check("err_busy", 32'(err_busy), 32'(m_err));
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b, input bit idle_after);
    logic [7:0] exp;
    if (m_m4) begin
      exp = b;
      strobe(rs, b[7:4], 1'b0, 8'h00);
      strobe(rs, b[3:0], 1'b1, exp);
    end else begin
      exp = {b[7:4], 4'h0};
      strobe(rs, b[7:4], 1'b1, exp);
    end
    model_exec(rs, exp);
    if (idle_after) wait_idle();
    check_state();
  endtask

  task automatic check_ddram(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); rd_addr = 5'(i);
      @(negedge clk);
      check(tag, 32'(rd_data), 32'(m_dd[i]));
    end
  endtask

  task automatic release_and_count_fill();
    int n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while (busy && n < 200) begin n++; @(negedge clk); end
    check("fill_cycles", 32'(n), 32'd32);
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_cmd", 32'({cmd_valid, cmd_rs, cmd_byte}), 32'd0);
    check_state();
    release_and_count_fill();
    check_ddram("fill_blank");

    // Power-up init sequence into 4-bit, two-line, display on
    send_byte(0, 8'h30, 1); send_byte(0, 8'h30, 1); send_byte(0, 8'h30, 1);
    send_byte(0, 8'h20, 1);
    check("mode4_after_init", 32'(mode_4bit), 32'd1);
    send_byte(0, 8'h28, 1); send_byte(0, 8'h0C, 1); send_byte(0, 8'h06, 1);

    send_byte(0, 8'h85, 1); send_byte(1, 8'h41, 1);
    check("cursor_after_A", 32'(cursor_idx), 32'd6);
    send_byte(0, 8'hCF, 1); send_byte(1, 8'h5A, 1);
    check("vis_at_0x50", 32'(cursor_vis), 32'd0);
    send_byte(0, 8'hA7, 1); send_byte(1, 8'h78, 1);
    check("wrap_to_0x40", 32'({cursor_vis, cursor_idx}), 32'h30);
    send_byte(0, 8'h04, 1); send_byte(0, 8'h80, 1); send_byte(1, 8'h79, 1);
    send_byte(0, 8'h06, 1); send_byte(1, 8'h71, 1);
    check("wrap_0x67_to_0", 32'({cursor_vis, cursor_idx}), 32'h20);
    check_ddram("dd_directed");

    // Randomized mix of instructions and data
    for (int k = 0; k < 50; k++) begin
      int op;
      op = int'($urandom_range(0, 15));
      if (op < 5)        send_byte(1, 8'($urandom_range(32, 126)), 1);
      else if (op < 7)   send_byte(0, 8'h80 | 8'($urandom_range(0, 127)), 1);
      else if (op == 7)  send_byte(0, 8'h04 | 8'($urandom_range(0, 3)), 1);
      else if (op == 8)  send_byte(0, 8'h08 | 8'($urandom_range(0, 7)), 1);
      else if (op < 11)  send_byte(0, 8'h10 | 8'($urandom_range(0, 15)), 1);
      else if (op == 11) send_byte(0, 8'h20 | 8'($urandom_range(0, 15) & 8'h0F), 1);
      else if (op == 12) send_byte(0, 8'h40 | 8'($urandom_range(0, 63)), 1);
      else if (op == 13) send_byte(0, 8'h02 | 8'($urandom_range(0, 1)), 1);
      else if (op == 14) send_byte(0, 8'h01, 1);
      else               send_byte(1, 8'($urandom_range(0, 255)), 1);
    end
    check_ddram("dd_random");

    // Data arriving during a clear fill is held and lands afterwards
    send_byte(0, 8'h80, 1);
    send_byte(0, 8'h06, 1);
    send_byte(0, 8'h01, 0);
    m_err = 1;
    send_byte(1, 8'h51, 1);
    check("err_busy_sticky", 32'(err_busy), 32'd1);
    check_ddram("dd_pending");

    // Reset between nibbles must restart in 8-bit mode
    strobe(0, 4'h3, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check("rst_mid_err", 32'(err_busy), 32'd0);
    release_and_count_fill();
    send_byte(0, 8'h30, 1);
    check("mode_after_rst", 32'(mode_4bit), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
